// File: rtl/scan_chain_ctrl.sv
`timescale 1ns/1ps
// scan_chain_ctrl
// Sequences one scan test on a serial chain of scan flops:
//   LOAD    - shift the latched pattern in, LSB first, SE=1
//   CAPTURE - one functional cycle with SE=0
//   UNLOAD  - shift the captured response out through SO, zeros in
//   DONE    - one-cycle done pulse with response and fail valid
// Chain order is SI -> cell[CHAIN_LEN-1] -> ... -> cell[0] -> SO, so the
// first bit shifted in ends in cell 0 and cell 0 is the first bit out.
// Every output is a flop. Output values are computed from the next state,
// so each output reflects the state that is current in that cycle.
// CNT_W must satisfy 2**CNT_W > CHAIN_LEN; the counter only ever runs
// 0..CHAIN_LEN-1 and is cleared whenever a state is entered.

module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response,
    output logic                 fail
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CAPTURE = 3'd2,
        S_UNLOAD  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Terminal count for both shift phases.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 last_bit;

    // Pattern still waiting to be shifted in; bit 0 is the next SI value.
    logic [CHAIN_LEN-1:0] pat_sh;
    logic [CHAIN_LEN-1:0] exp_lat;
    // Response being assembled during UNLOAD; SO enters at the top and
    // walks down, so after CHAIN_LEN shifts bit i holds cell i.
    logic [CHAIN_LEN-1:0] resp_sh;
    logic [CHAIN_LEN-1:0] resp_nxt;

    assign last_bit = (cnt == LAST_BIT);
    assign resp_nxt = {SO, resp_sh[CHAIN_LEN-1:1]};

    // State and bit-counter register.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: flops take non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and counter decode.
    always_comb begin
        // NOTE: defaults first, so every path assigns every variable and
        // no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = '0;
                end
            end
            S_LOAD: begin
                if (last_bit) begin
                    state_nxt = S_CAPTURE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                state_nxt = S_UNLOAD;
                cnt_nxt   = '0;
            end
            S_UNLOAD: begin
                if (last_bit) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Registered control outputs, decoded from the state being entered.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            SE   <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            SE   <= (state_nxt == S_LOAD) || (state_nxt == S_UNLOAD);
            busy <= (state_nxt != S_IDLE);
            done <= (state_nxt == S_DONE);
        end
    end

    // Pattern/expected latches, SI driver and response assembly.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            // NOTE: the latched vectors are plain registers, not a memory,
            // so clearing them on reset is cheap and keeps them defined.
            SI       <= 1'b0;
            pat_sh   <= '0;
            exp_lat  <= '0;
            resp_sh  <= '0;
            response <= '0;
            fail     <= 1'b0;
        end else begin
            SI <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        // First bit goes out in the first LOAD cycle.
                        SI       <= pattern[0];
                        pat_sh   <= pattern >> 1;
                        exp_lat  <= expected;
                        resp_sh  <= '0;
                        response <= '0;
                        fail     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // On the final LOAD edge the chain is full; CAPTURE
                    // drives SI low.
                    if (!last_bit) begin
                        SI <= pat_sh[0];
                    end
                    pat_sh <= pat_sh >> 1;
                end
                S_UNLOAD: begin
                    resp_sh <= resp_nxt;
                    if (last_bit) begin
                        response <= resp_nxt;
                        fail     <= (resp_nxt != exp_lat);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
`timescale 1ns/1ps
// Bench for scan_chain_ctrl: a behavioural scan chain (invert, identity or
// rotate capture function) plus a cycle-count reference model of the
// controller. Outputs are compared against the model on every falling edge,
// and directed scenarios pin literal values.

module tb_scan_chain_ctrl;

    localparam int N     = 8;
    localparam int CNT_W = 4;
    localparam int T_DONE = 2 * N + 2;

    logic         CK = 1'b0;
    logic         RN;
    logic         start;
    logic [N-1:0] pattern;
    logic [N-1:0] expected;
    logic         SO;
    logic         SE;
    logic         SI;
    logic         busy;
    logic         done;
    logic [N-1:0] response;
    logic         fail;

    int n_tests = 0;
    int n_fail  = 0;

    scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(CNT_W)) dut (
        .CK       (CK),
        .RN       (RN),
        .start    (start),
        .pattern  (pattern),
        .expected (expected),
        .SO       (SO),
        .SE       (SE),
        .SI       (SI),
        .busy     (busy),
        .done     (done),
        .response (response),
        .fail     (fail)
    );

    always #5 CK = ~CK;

    // ---------------- scan chain environment ----------------
    // mode 0: D = ~Q, mode 1: D = Q, mode 2: D[i] = Q[(i+1) % N]
    int           mode = 0;
    logic [N-1:0] chain;

    function automatic logic [N-1:0] capture_fn(input logic [N-1:0] q, input int md);
        case (md)
            0:       return ~q;
            1:       return q;
            default: return {q[0], q[N-1:1]};
        endcase
    endfunction

    always @(posedge CK or negedge RN) begin
        if (!RN)     chain <= '0;
        else if (SE) chain <= {SI, chain[N-1:1]};
        else         chain <= capture_fn(chain, mode);
    end

    assign SO = chain[0];

    // ---------------- reference model ----------------
    // t = cycles since an accepted start (0 when idle). Cycle t of a run:
    // LOAD 1..N (SI = pattern[t-1]), CAPTURE N+1, UNLOAD N+2..2N+1, DONE 2N+2.
    int           t = 0;
    logic [N-1:0] m_pat  = '0;
    logic [N-1:0] m_exp  = '0;
    logic [N-1:0] m_resp = '0;
    logic         m_fail = 1'b0;

    always @(posedge CK or negedge RN) begin
        if (!RN) begin
            t      = 0;
            m_resp = '0;
            m_fail = 1'b0;
        end else if (t == 0) begin
            if (start) begin
                t      = 1;
                m_pat  = pattern;
                m_exp  = expected;
                m_resp = '0;
                m_fail = 1'b0;
            end
        end else if (t == T_DONE) begin
            t = 0;
        end else begin
            t = t + 1;
            if (t == T_DONE) begin
                m_resp = capture_fn(m_pat, mode);
                m_fail = (m_resp != m_exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    logic chk_en = 1'b0;
    always @(negedge CK) begin
        if (chk_en) begin
            check("cyc_SE",   SE,   32'((t >= 1 && t <= N) || (t >= N + 2 && t <= 2 * N + 1)));
            check("cyc_SI",   SI,   32'((t >= 1 && t <= N) ? m_pat[t-1] : 1'b0));
            check("cyc_busy", busy, 32'(t != 0));
            check("cyc_done", done, 32'(t == T_DONE));
            check("cyc_resp", response, 32'(m_resp));
            check("cyc_fail", fail, 32'(m_fail));
        end
    end

    // ---------------- helpers ----------------
    // Called at the falling edge of cycle 1 of a run; returns the cycle in
    // which done was seen plus the SI and SE traces of the run.
    task automatic wait_done(output int cyc, output logic [N-1:0] si_seq,
                             output logic [2*N:0] se_seq);
        int c;
        c      = 1;
        cyc    = -1;
        si_seq = '0;
        se_seq = '0;
        while (c <= 4 * N) begin
            if (c <= N)         si_seq[c-1] = SI;
            if (c <= 2 * N + 1) se_seq[c-1] = SE;
            if (done === 1'b1) begin
                cyc = c;
                check("chain_zero_at_done", chain, 0);
                break;
            end
            @(negedge CK);
            c++;
        end
        if (cyc < 0) check("done_timeout", done, 1);
    endtask

    task automatic run_one(input logic [N-1:0] p, input logic [N-1:0] e, input int md,
                           output int cyc, output logic [N-1:0] resp, output logic f,
                           output logic [N-1:0] si_seq, output logic [2*N:0] se_seq);
        @(negedge CK);
        mode     = md;
        pattern  = p;
        expected = e;
        start    = 1'b1;
        @(negedge CK);
        start    = 1'b0;
        pattern  = N'($urandom);
        expected = N'($urandom);
        wait_done(cyc, si_seq, se_seq);
        resp = response;
        f    = fail;
    endtask

    // ---------------- stimulus ----------------
    int           cyc;
    logic [N-1:0] resp;
    logic         f;
    logic [N-1:0] si_seq;
    logic [2*N:0] se_seq;
    int           n_done;
    int           done_at;

    initial begin
        RN       = 1'b1;
        start    = 1'b0;
        pattern  = '0;
        expected = '0;
        #1;
        // Reset for three cycles with start held high.
        RN     = 1'b0;
        start  = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge CK);
        check("rst_SE",   SE,   0);
        check("rst_SI",   SI,   0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_resp", response, 0);
        check("rst_fail", fail, 0);
        @(posedge CK);
        #2;
        RN    = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge CK);
        check("idle_busy", busy, 0);

        // Pass case: invert chain.
        run_one(8'hA5, 8'h5A, 0, cyc, resp, f, si_seq, se_seq);
        check("pass_cycle", cyc, T_DONE);
        check("pass_si_seq", si_seq, 8'hA5);
        check("pass_se_seq", se_seq, 17'h1FEFF);
        check("pass_resp", resp, 8'h5A);
        check("pass_fail", f, 0);

        // Fail case: response and fail held until the next start.
        run_one(8'h0F, 8'hFF, 0, cyc, resp, f, si_seq, se_seq);
        check("fail_cycle", cyc, T_DONE);
        check("fail_resp", resp, 8'hF0);
        check("fail_flag", f, 1);
        repeat (5) @(negedge CK);
        check("fail_hold_resp", response, 8'hF0);
        check("fail_hold_flag", fail, 1);
        start    = 1'b1;
        pattern  = 8'h12;
        expected = 8'hED;
        @(posedge CK);
        #1;
        check("clear_resp", response, 0);
        check("clear_fail", fail, 0);
        @(negedge CK);
        start = 1'b0;
        wait_done(cyc, si_seq, se_seq);
        check("clr_run_resp", response, 8'hED);

        // Start while busy: pulses in cycles 5, 12, 18 ignored; cycle 19 accepted.
        @(negedge CK);
        mode     = 0;
        pattern  = 8'h12;
        expected = 8'hED;
        start    = 1'b1;
        n_done   = 0;
        done_at  = -1;
        for (int c = 1; c <= 19; c++) begin
            @(negedge CK);
            if (done === 1'b1) begin
                n_done++;
                done_at = c;
            end
            if (c == 19) check("busy_c19", busy, 0);
            start    = (c == 5 || c == 12 || c == 18 || c == 19);
            pattern  = (c == 19) ? 8'h66 : N'($urandom);
            expected = (c == 19) ? 8'h99 : N'($urandom);
        end
        check("busy_done_count", n_done, 1);
        check("busy_done_at", done_at, T_DONE);
        @(negedge CK);
        start = 1'b0;
        check("restart_busy", busy, 1);
        wait_done(cyc, si_seq, se_seq);
        check("restart_cycle", cyc, T_DONE);
        check("restart_resp", response, 8'h99);
        check("restart_fail", fail, 0);

        // Reset in UNLOAD cycle 13 aborts without a done pulse.
        @(negedge CK);
        pattern  = 8'hC3;
        expected = 8'h3C;
        start    = 1'b1;
        @(negedge CK);
        start = 1'b0;
        repeat (12) @(posedge CK);
        #1;
        check("abort_pre_SE", SE, 1);
        #1;
        RN = 1'b0;
        #1;
        check("abort_SE",   SE,   0);
        check("abort_SI",   SI,   0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_resp", response, 0);
        @(posedge CK);
        #2;
        RN     = 1'b1;
        n_done = 0;
        repeat (T_DONE + 2) begin
            @(negedge CK);
            if (done === 1'b1) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_one(8'hC3, 8'h3C, 0, cyc, resp, f, si_seq, se_seq);
        check("after_abort_cycle", cyc, T_DONE);
        check("after_abort_resp", resp, 8'h3C);
        check("after_abort_fail", f, 0);

        // Identity chain.
        run_one(8'h3C, 8'h3C, 1, cyc, resp, f, si_seq, se_seq);
        check("ident_cycle", cyc, T_DONE);
        check("ident_resp", resp, 8'h3C);
        check("ident_fail", f, 0);

        // Rotating chain pins bit ordering: resp[i] = pattern[(i+1)%N].
        run_one(8'h81, 8'h00, 2, cyc, resp, f, si_seq, se_seq);
        check("rot_resp", resp, 8'hC0);
        check("rot_fail", f, 1);

        // Randomized traffic: random starts, patterns and expectations.
        for (int blk = 0; blk < 6; blk++) begin
            @(negedge CK);
            mode = int'($urandom_range(0, 2));
            for (int c = 0; c < 80; c++) begin
                @(negedge CK);
                start   = ($urandom_range(0, 2) == 0);
                pattern = N'($urandom);
                if ($urandom_range(0, 1) == 1) expected = capture_fn(pattern, mode);
                else                           expected = N'($urandom);
            end
            @(negedge CK);
            start = 1'b0;
            repeat (T_DONE + 2) @(negedge CK);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

endmodule
